// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter (rfd/din/din_vld handshake)
// between N_REQ byte-stream requesters. Round-robin arbitration is done at
// packet granularity: a grant is held until the owner marks its last byte,
// or until MAX_BURST bytes have been sent, whichever comes first.
//
// Optional build macro: UART_ARB_HDR_EN
//   When defined, every new grant first sends a header byte 8'hA0 | g[3:0]
//   ahead of the owner's payload. The header does not count toward
//   MAX_BURST, and a regrant after a forced release also sends one.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   req_vld   per-requester byte valid
//   req_data  per-requester byte, requester i at [i*DI_WIDTH +: DI_WIDTH]
//   req_last  byte is the last of its packet (qualified by req_vld)
//   req_rdy   byte accepted from requester i this cycle (combinational)
//   rfd       UART ready for data
//   din       byte to UART (holding register)
//   din_vld   byte valid to UART (combinational, only in SEND with rfd=1)
//   grant     one-hot current owner, 0 when idle
//   busy      arbiter not idle
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DI_WIDTH  = 8,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ*DI_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_rdy,
    input  logic                      rfd,
    output logic [DI_WIDTH-1:0]       din,
    output logic                      din_vld,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_RFD
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DI_WIDTH-1:0]  hold_q, hold_d;
    logic                 last_q, last_d;
`ifdef UART_ARB_HDR_EN
    logic                 hdr_q, hdr_d;
`endif

    logic [PTR_W-1:0]     pick;
    logic                 found;
    logic [PTR_W:0]       sum;
    logic [DI_WIDTH-1:0]  req_bytes [N_REQ];

    // Unpack the flat data bus into one byte per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DI_WIDTH +: DI_WIDTH];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
`ifdef UART_ARB_HDR_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
`ifdef UART_ARB_HDR_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    // Next-state logic and round-robin pick.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        last_d  = last_q;
`ifdef UART_ARB_HDR_EN
        hdr_d   = hdr_q;
`endif
        pick    = '0;
        found   = 1'b0;
        sum     = '0;

        // First requester at or after the pointer, wrapping modulo N_REQ.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_vld[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[PTR_W-1:0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = N_REQ'(1) << pick;
                    gidx_d  = pick;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef UART_ARB_HDR_EN
                    hold_d  = DI_WIDTH'(8'hA0 | {4'h0, 4'(pick)});
                    hdr_d   = 1'b1;
                    state_d = SEND;
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                if (req_vld[gidx_q]) begin
                    hold_d  = req_bytes[gidx_q];
                    last_d  = req_last[gidx_q];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rfd) begin
`ifdef UART_ARB_HDR_EN
                    if (!hdr_q) begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                    hdr_d = 1'b0;
`else
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`endif
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!rfd) begin
                    state_d = WAIT_RFD;
                end
            end
            WAIT_RFD: begin
                if (rfd) begin
                    // After a header both last_q and cnt_q are clear, so this
                    // always continues into LOAD for the first payload byte.
                    if (last_q || (cnt_q == CNT_W'(MAX_BURST))) begin
                        grant_d = '0;
                        ptr_d   = (gidx_q == PTR_W'(N_REQ - 1)) ? '0
                                                                : gidx_q + PTR_W'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_rdy = (state_q == LOAD) ? (req_vld & grant_q) : '0;
    assign din_vld = (state_q == SEND) && rfd;
    assign din     = hold_q;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (N_REQ=4, DI_WIDTH=8, MAX_BURST=3).
// A UART model drops rfd for two cycles after each accepted byte; requester
// models present queued bytes and pop them on req_rdy. Every UART byte is
// logged as {grant, din} and compared against a hand-written expected list.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 3;
`ifdef UART_ARB_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic           rfd;
    logic [W-1:0]   din;
    logic           din_vld;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (N),
        .DI_WIDTH (W),
        .MAX_BURST(MB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_data(req_data),
        .req_last(req_last),
        .req_rdy (req_rdy),
        .rfd     (rfd),
        .din     (din),
        .din_vld (din_vld),
        .grant   (grant),
        .busy    (busy)
    );

    int          total;
    int          bad;
    logic [8:0]  src_q [N][$];
    logic [11:0] log_q [$];
    logic [11:0] exp_q [$];
    int          log_n [$];
    int          ncnt;
    int          start_n;
    bit          uart_stall;
    bit          pend;
    int          bcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_grant(input int g);
        if (HDR) exp_q.push_back({4'(1 << g), 8'hA0 | 8'(g)});
    endfunction

    function automatic void exp_byte(input int g, input logic [7:0] d);
        exp_q.push_back({4'(1 << g), d});
    endfunction

    function automatic bool_t_dummy();
        return 0;
    endfunction

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input string tag);
        int k = 0;
        while (k < 400 && !(srcs_empty() && !busy && !pend && bcnt == 0)) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_done"}, 32'(k < 400), 32'd1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF, 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
        log_n.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_din"},     32'(din),     32'd0);
        check({tag, "_din_vld"}, 32'(din_vld), 32'd0);
        check({tag, "_grant"},   32'(grant),   32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    endtask

    // UART and requester models, all driven on the falling edge.
    initial begin
        logic [8:0] ent;
        req_vld  = '0;
        req_data = '0;
        req_last = '0;
        rfd      = 1'b1;
        ncnt     = 0;
        pend     = 1'b0;
        bcnt     = 0;
        forever begin
            @(negedge clk);
            ncnt++;
            if (!rst) begin
                pend = 1'b0;
                bcnt = 0;
                rfd  = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                bcnt = 2;
                rfd  = 1'b0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) rfd = !uart_stall;
            end else begin
                rfd = !uart_stall;
            end
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    ent = src_q[i][0];
                    req_vld[i]          = 1'b1;
                    req_data[i*W +: W]  = ent[7:0];
                    req_last[i]         = ent[8];
                end else begin
                    req_vld[i]          = 1'b0;
                    req_data[i*W +: W]  = '0;
                    req_last[i]         = 1'b0;
                end
            end
            #1;
            if (din_vld) begin
                log_q.push_back({grant, din});
                log_n.push_back(ncnt);
                pend = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_rdy[i]) void'(src_q[i].pop_front());
            end
        end
    end

    initial begin
        int k;
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        uart_stall = 1'b0;
        start_n    = 0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single byte from requester 0.
        start_n = ncnt + 1;
        src_q[0].push_back({1'b1, 8'h64});
        exp_grant(0); exp_byte(0, 8'h64);
        wait_done("s1");
        if (!HDR && log_n.size() > 0) check("s1_latency", 32'(log_n[0] - start_n), 32'd2);
        check("s1_grant_after", 32'(grant), 32'd0);
        check("s1_din_held",    32'(din),   32'h64);
        compare_log("s1");

        // Simultaneous 1-byte packets from requesters 1 and 2.
        src_q[1].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h22});
        exp_grant(1); exp_byte(1, 8'h11);
        exp_grant(2); exp_byte(2, 8'h22);
        wait_done("s2");
        compare_log("s2");

        // Pointer is 3: requester 3 first, then 0 holds its packet over 1.
        src_q[0].push_back({1'b0, 8'h01});
        src_q[0].push_back({1'b0, 8'h02});
        src_q[0].push_back({1'b1, 8'h03});
        src_q[3].push_back({1'b1, 8'h33});
        src_q[1].push_back({1'b1, 8'h44});
        exp_grant(3); exp_byte(3, 8'h33);
        exp_grant(0); exp_byte(0, 8'h01); exp_byte(0, 8'h02); exp_byte(0, 8'h03);
        exp_grant(1); exp_byte(1, 8'h44);
        wait_done("s3");
        compare_log("s3");

        // Forced release after MAX_BURST=3 bytes; requester 1 slips in.
        src_q[0].push_back({1'b0, 8'hB0});
        src_q[0].push_back({1'b0, 8'hB1});
        src_q[0].push_back({1'b0, 8'hB2});
        src_q[0].push_back({1'b0, 8'hB3});
        src_q[0].push_back({1'b1, 8'hB4});
        src_q[1].push_back({1'b1, 8'h55});
        exp_grant(0); exp_byte(0, 8'hB0); exp_byte(0, 8'hB1); exp_byte(0, 8'hB2);
        exp_grant(1); exp_byte(1, 8'h55);
        exp_grant(0); exp_byte(0, 8'hB3); exp_byte(0, 8'hB4);
        wait_done("s4");
        compare_log("s4");

        // UART not ready: the byte must wait with din_vld low.
        uart_stall = 1'b1;
        src_q[2].push_back({1'b1, 8'h77});
        repeat (8) @(posedge clk);
        #1;
        check("s5_busy",    32'(busy),         32'd1);
        check("s5_grant",   32'(grant),        32'h4);
        check("s5_din_vld", 32'(din_vld),      32'd0);
        check("s5_req_rdy", 32'(req_rdy),      32'd0);
        check("s5_nolog",   32'(log_q.size()), 32'd0);
        uart_stall = 1'b0;
        exp_grant(2); exp_byte(2, 8'h77);
        wait_done("s5");
        compare_log("s5");

        // Reset while waiting for the UART to go busy.
        src_q[2].push_back({1'b1, 8'h99});
        k = 0;
        while (log_q.size() == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("s6_seen", 32'(log_q.size() > 0), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("s6_rst");
        for (int i = 0; i < N; i++) src_q[i].delete();
        log_q.delete();
        exp_q.delete();
        log_n.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        src_q[1].push_back({1'b1, 8'h1A});
        src_q[3].push_back({1'b1, 8'h3A});
        exp_grant(1); exp_byte(1, 8'h1A);
        exp_grant(3); exp_byte(3, 8'h3A);
        wait_done("s6");
        compare_log("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (rfd/din/din_vld handshake) between N byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held until the requester marks the last byte, or until MAX_BURST bytes have been sent.
- Sits between producer blocks (status, debug, command response) and the UART TX interface.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DI_WIDTH, 8, byte width; must match the UART DI_WIDTH
- MAX_BURST, 64, maximum bytes per grant before forced release (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req_vld  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*DI_WIDTH  per-requester byte; requester i uses bits [i*DI_WIDTH +: DI_WIDTH]
- req_last  in  N_REQ  byte is the last of the packet; qualified by req_vld
- req_rdy  out  N_REQ  byte accepted from requester i this cycle
- rfd  in  1  UART ready for data
- din  out  DI_WIDTH  byte to UART
- din_vld  out  1  byte valid to UART
- grant  out  N_REQ  one-hot current owner; 0 when idle
- busy  out  1  grant held or byte in flight

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - outputs: req_rdy=0, din=0, din_vld=0, grant=0, busy=0
  - internal: state=IDLE, round-robin pointer=0, burst counter=0
- Reset mid-packet aborts the packet silently; the partial packet is not resumed.
- States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_RFD.
- IDLE:
  - If any req_vld is high, pick the first requesting index at or after the pointer, wrapping modulo N_REQ.
  - Register grant one-hot, clear the burst counter, go to LOAD.
- LOAD:
  - req_rdy[g] = req_vld[g], combinational, asserted only in LOAD.
  - When req_vld[g]=1: capture the byte into the holding register, latch req_last, go to SEND.
  - Otherwise stay in LOAD with grant held; the owner may stall mid-packet.
- SEND:
  - din = holding register.
  - din_vld=1 for exactly one cycle, and only in a cycle where rfd=1; otherwise wait with din_vld=0.
  - On transfer: increment the burst counter, go to WAIT_BUSY.
- WAIT_BUSY: wait for rfd=0, then go to WAIT_RFD.
- WAIT_RFD: wait for rfd=1, then:
  - If the latched last was set, or the burst counter equals MAX_BURST: release (grant=0), set pointer = g+1 mod N_REQ, go to IDLE.
  - Otherwise go to LOAD with the same grant.
- din holds its value until the next capture; din_vld is never high outside SEND.
- Latency: req_vld sampled in IDLE -> req_rdy in the next cycle (LOAD) -> din_vld in the following cycle if rfd=1. Minimum is 2 cycles from arbitration to UART issue.
- Forced release at MAX_BURST does not drop data: the requester resumes at its next grant, and the bytes stay contiguous on its own stream.
- Simultaneous requests: only the pointer order matters. A requester that releases and immediately re-requests loses to any other pending requester.
- busy = (state != IDLE).
- The burst counter is 8 bits, saturating; it cannot wrap because MAX_BURST ≤ 255.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - At each new grant, a header byte 8'hA0 | g[3:0] is sent before the first payload byte.
  - Flow: IDLE -> SEND (header) -> WAIT_BUSY -> WAIT_RFD -> LOAD.
  - The header does not count toward MAX_BURST.
  - A forced-release regrant also emits a header.
- Undefined: no header; payload only, as above.

Test Plan:
- Single byte: rst released, requester 0 sends 8'h64 with last=1, rfd=1 → din=8'h64, din_vld pulses once 2 cycles after req_vld; grant returns to 0 after rfd falls then rises.
- Round-robin: requesters 1 and 2 each send a 1-byte packet (8'h11, 8'h22) simultaneously, pointer=0 → UART sees 8'h11 then 8'h22; pointer ends at 3.
- Packet hold: requester 0 sends 3 bytes (8'h01, 8'h02, 8'h03, last on the third) while requester 3 is pending → all three bytes precede requester 3's byte.
- Forced release: MAX_BURST=2, requester 0 sends 5 bytes with no last while requester 1 sends 1 byte → order is 0, 0, 1, 0, 0, 0.
- Reset mid-operation: rst asserted while in WAIT_BUSY → all outputs are 0 immediately; the next packet arbitrates from pointer 0.
- With UART_ARB_HDR_EN defined: requester 2 sends 8'h5A with last=1 → UART sees 8'hA2 then 8'h5A.
